video_mode_ctrl: RTL and testbench

Parametrised video-output mode controller for the chip8 board tops: power-on reset generation, boot-time mode default from the scandoubler settings byte in SRAM, debounced key cycling over a configurable number of modes, direct mode selection from the OSD control module, and final HS/VS pin muxing for VGA, 15 kHz RGB and composite. It also stretches the host reset into the core reset. It sits between the chip8 machine/CtrlModule and the VGA sync pins, and replaces the ad-hoc POR, videomode and reset-counter logic of the per-board tops.

---
 rtl/video_mode_ctrl.sv | 177 +++++++++++++++++
 tb/tb_video_mode_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: video output mode controller for the chip8 board tops.
// Generates the power-on phase, picks the boot mode from the scandoubler
// settings byte, cycles modes on a debounced key release or loads a mode
// directly from the OSD, stretches the host reset into the core reset and
// muxes the core syncs onto the board VGA sync pins.
module video_mode_ctrl #(
  parameter int NUM_MODES       = 2,
  parameter int POR_CYCLES      = 255,
  parameter int CORE_RST_CYCLES = 255,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEFAULT_BIT     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sram_data,
  input  logic       key_mode,
  input  logic       sel_valid,
  input  logic [1:0] sel_mode,
  input  logic       host_reset_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       clkcolor,
  output logic [1:0] mode,
  output logic       por,
  output logic       core_reset,
  output logic       mode_change,
  output logic       hsync_out,
  output logic       vsync_out
);

  localparam int POR_W  = $clog2(POR_CYCLES);
  localparam int CRST_W = $clog2(CORE_RST_CYCLES) + 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_CYCLES - 1);
  localparam logic [CRST_W-1:0] CRST_LAST = CRST_W'(CORE_RST_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]        LAST_MODE = 2'(NUM_MODES - 1);
  localparam logic [2:0]        MODE_COUNT = 3'(NUM_MODES);

  logic [POR_W-1:0]  por_cnt;
  logic              sram_bit;
  logic              key_s1;
  logic              key_sync;
  logic              key_deb;
  logic              key_deb_d;
  logic [DEB_W-1:0]  deb_cnt;
  logic              host_s1;
  logic              host_sync;
  logic [CRST_W-1:0] crst_cnt;
  logic [1:0]        mode_next;
  logic              key_release;
  logic              sel_ok;
  logic              boot_load;
  logic              csync;
  logic              unused_settings;

  // Only the selected settings bit matters; the others are consumed here so they read as intentional.
  assign unused_settings = ^sram_data;

  assign key_release = key_deb_d & ~key_deb;
  assign sel_ok      = sel_valid && ({1'b0, sel_mode} < MODE_COUNT);
  assign boot_load   = por && (por_cnt == POR_LAST);
  assign csync       = ~(hsync_in ^ vsync_in);

  // Power-on phase: count up after reset release, drop por once the last count is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      por_cnt <= '0;
      por     <= 1'b1;
    end else if (por) begin
      if (por_cnt == POR_LAST)
        por <= 1'b0;
      else
        por_cnt <= por_cnt + POR_W'(1);
    end
  end

  // Capture the boot-mode settings bit while the SRAM is held at the settings address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sram_bit <= 1'b0;
    else if (por)
      sram_bit <= sram_data[DEFAULT_BIT];
  end

  // Two-flop synchronisers for the raw key level and the host reset request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1    <= 1'b0;
      key_sync  <= 1'b0;
      host_s1   <= 1'b0;
      host_sync <= 1'b0;
    end else begin
      key_s1    <= key_mode;
      key_sync  <= key_s1;
      host_s1   <= host_reset_n;
      host_sync <= host_s1;
    end
  end

  // Debouncer: the level follows the synced key only after a full run of disagreeing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt   <= '0;
      key_deb   <= 1'b0;
      key_deb_d <= 1'b0;
    end else begin
      key_deb_d <= key_deb;
      if (key_sync == key_deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_deb <= key_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Next mode: a legal OSD select beats a key release; nothing changes during the power-on phase.
  always_comb begin
    mode_next = mode;
    if (!por) begin
      if (sel_ok)
        mode_next = sel_mode;
      else if (key_release)
        mode_next = (mode == LAST_MODE) ? 2'd0 : mode + 2'd1;
    end
  end

  // Mode register with boot load, plus a change pulse aligned with the first cycle of a new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode        <= 2'd0;
      mode_change <= 1'b0;
    end else if (boot_load) begin
      mode        <= sram_bit ? 2'd0 : 2'd1;
      mode_change <= 1'b0;
    end else begin
      mode        <= mode_next;
      mode_change <= (mode_next != mode);
    end
  end

  // Core reset: held while por or host reset is active, then stretched for a fixed number of cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crst_cnt   <= '0;
      core_reset <= 1'b1;
    end else if (por || !host_sync) begin
      crst_cnt   <= '0;
      core_reset <= 1'b1;
    end else if (core_reset) begin
      if (crst_cnt == CRST_LAST)
        core_reset <= 1'b0;
      else
        crst_cnt <= crst_cnt + CRST_W'(1);
    end
  end

  // Sync pin mux: VGA passes syncs through, RGB/composite modes drive composite sync on HS.
  always_comb begin
    hsync_out = csync;
    vsync_out = 1'b1;
    case (mode)
      2'd0: begin
        hsync_out = hsync_in;
        vsync_out = vsync_in;
      end
      2'd1:    vsync_out = 1'b1;
      2'd2:    vsync_out = clkcolor;
      default: vsync_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: directed bench for video_mode_ctrl with a mode_change scoreboard.
// Expected new mode values are queued when stimulus is issued; a monitor pops and
// compares them whenever the DUT raises mode_change.
module tb_video_mode_ctrl;

  localparam int POR_CYCLES      = 255;
  localparam int CORE_RST_CYCLES = 255;
  localparam int DEBOUNCE_CYCLES = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sram_data = 8'h00;
  logic       key_mode = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_mode = 2'd0;
  logic       host_reset_n = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       clkcolor = 1'b0;
  logic [1:0] mode;
  logic       por;
  logic       core_reset;
  logic       mode_change;
  logic       hsync_out;
  logic       vsync_out;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  video_mode_ctrl #(
    .NUM_MODES      (3),
    .POR_CYCLES     (POR_CYCLES),
    .CORE_RST_CYCLES(CORE_RST_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DEFAULT_BIT    (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sram_data   (sram_data),
    .key_mode    (key_mode),
    .sel_valid   (sel_valid),
    .sel_mode    (sel_mode),
    .host_reset_n(host_reset_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .clkcolor    (clkcolor),
    .mode        (mode),
    .por         (por),
    .core_reset  (core_reset),
    .mode_change (mode_change),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic key, input logic sv, input logic [1:0] sm);
    key_mode  = key;
    sel_valid = sv;
    sel_mode  = sm;
  endtask

  // Full key press and release; mode must move exactly 2+DEBOUNCE+1 edges after release.
  task automatic pressRelease(input logic [1:0] old_mode, input logic [1:0] new_mode);
    applyStimulus(1'b1, 1'b0, 2'd0);
    tick(30);
    checkOutput("mode unchanged on key press", mode, old_mode);
    exp_q.push_back(new_mode);
    applyStimulus(1'b0, 1'b0, 2'd0);
    tick(2 + DEBOUNCE_CYCLES);
    checkOutput("mode before key release takes effect", mode, old_mode);
    tick(1);
    checkOutput("mode after key release", mode, new_mode);
    tick(5);
  endtask

  // One-cycle OSD select strobe; mode is checked right after the loading edge.
  task automatic select(input logic [1:0] req, input logic [1:0] expect_mode);
    applyStimulus(1'b0, 1'b1, req);
    tick(1);
    applyStimulus(1'b0, 1'b0, 2'd0);
    checkOutput("mode after sel_valid", mode, expect_mode);
    tick(3);
  endtask

  // Scoreboard monitor: every mode_change pulse must match the next queued mode.
  always @(negedge clk) begin
    if (!reset && mode_change === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected mode_change: mode %0d, no pulse expected", mode);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("mode_change value", {6'd0, mode}, {6'd0, mon_exp});
      end
    end
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting video_mode_ctrl bench");

    // Reset state while reset is held.
    tick(3);
    checkOutput("reset mode", mode, 2'd0);
    checkOutput("reset por", por, 1'b1);
    checkOutput("reset core_reset", core_reset, 1'b1);
    checkOutput("reset mode_change", mode_change, 1'b0);

    // Boot with settings bit clear: RGB mode, no change pulse.
    reset = 1'b0;
    tick(POR_CYCLES - 1);
    checkOutput("por still high before last cycle", por, 1'b1);
    checkOutput("mode still 0 during por", mode, 2'd0);
    tick(1);
    checkOutput("por low after POR_CYCLES", por, 1'b0);
    checkOutput("boot mode with sram 00", mode, 2'd1);

    // Core reset stretch after por falls.
    tick(CORE_RST_CYCLES - 1);
    checkOutput("core_reset held during stretch", core_reset, 1'b1);
    tick(1);
    checkOutput("core_reset released after stretch", core_reset, 1'b0);

    // Sync mux in RGB csync mode.
    hsync_in = 1'b0; vsync_in = 1'b1; #1;
    checkOutput("mode1 hsync h0 v1", hsync_out, 1'b0);
    checkOutput("mode1 vsync h0 v1", vsync_out, 1'b1);
    hsync_in = 1'b0; vsync_in = 1'b0; #1;
    checkOutput("mode1 hsync h0 v0", hsync_out, 1'b1);
    checkOutput("mode1 vsync h0 v0", vsync_out, 1'b1);

    // Host reset pulse of 5 cycles, then the full stretch.
    host_reset_n = 1'b0;
    tick(5);
    checkOutput("core_reset during host reset", core_reset, 1'b1);
    host_reset_n = 1'b1;
    tick(2 + CORE_RST_CYCLES - 1);
    checkOutput("core_reset before host stretch ends", core_reset, 1'b1);
    tick(1);
    checkOutput("core_reset after host stretch", core_reset, 1'b0);

    // Second host pulse in the middle of a stretch restarts it.
    host_reset_n = 1'b0;
    tick(5);
    host_reset_n = 1'b1;
    tick(100);
    host_reset_n = 1'b0;
    tick(3);
    checkOutput("core_reset during mid-stretch pulse", core_reset, 1'b1);
    host_reset_n = 1'b1;
    tick(2 + CORE_RST_CYCLES - 1);
    checkOutput("core_reset restarted stretch still high", core_reset, 1'b1);
    tick(1);
    checkOutput("core_reset after restarted stretch", core_reset, 1'b0);

    // Asynchronous reset mid-operation, then boot with settings bit set: VGA.
    reset = 1'b1;
    sram_data = 8'h01;
    #1;
    checkOutput("async reset mode", mode, 2'd0);
    checkOutput("async reset por", por, 1'b1);
    checkOutput("async reset core_reset", core_reset, 1'b1);
    tick(1);
    reset = 1'b0;
    tick(POR_CYCLES);
    checkOutput("por low after second boot", por, 1'b0);
    checkOutput("boot mode with sram 01", mode, 2'd0);

    // Key cycling over three modes, including wrap.
    pressRelease(2'd0, 2'd1);
    pressRelease(2'd1, 2'd2);
    pressRelease(2'd2, 2'd0);

    // A 10-cycle glitch on the key must not change the mode.
    applyStimulus(1'b1, 1'b0, 2'd0);
    tick(10);
    applyStimulus(1'b0, 1'b0, 2'd0);
    tick(40);
    checkOutput("mode after key glitch", mode, 2'd0);

    // Direct selection: legal, out-of-range, and same-as-current.
    exp_q.push_back(2'd2);
    select(2'd2, 2'd2);
    select(2'd3, 2'd2);
    select(2'd2, 2'd2);
    exp_q.push_back(2'd0);
    select(2'd0, 2'd0);

    // Key release edge coincident with sel_valid selecting the current mode.
    applyStimulus(1'b1, 1'b0, 2'd0);
    tick(30);
    applyStimulus(1'b0, 1'b0, 2'd0);
    tick(2 + DEBOUNCE_CYCLES);
    applyStimulus(1'b0, 1'b1, 2'd0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 2'd0);
    checkOutput("mode with simultaneous sel and key", mode, 2'd0);
    tick(30);
    checkOutput("key edge discarded after sel", mode, 2'd0);

    // Composite mode: vsync_out follows clkcolor.
    exp_q.push_back(2'd2);
    select(2'd2, 2'd2);
    clkcolor = 1'b1; #1;
    checkOutput("mode2 vsync clkcolor 1", vsync_out, 1'b1);
    clkcolor = 1'b0; #1;
    checkOutput("mode2 vsync clkcolor 0", vsync_out, 1'b0);
    hsync_in = 1'b1; vsync_in = 1'b0; #1;
    checkOutput("mode2 hsync csync", hsync_out, 1'b0);

    // VGA passthrough.
    exp_q.push_back(2'd0);
    select(2'd0, 2'd0);
    checkOutput("mode0 hsync passthrough", hsync_out, 1'b1);
    checkOutput("mode0 vsync passthrough", vsync_out, 1'b0);

    tick(5);
    checkOutput("scoreboard drained", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
